riscv_mc_control: RTL and testbench
===================================

// Module: riscv_mc_control
// PURPOSE
//  Multi-cycle control unit for the next-generation RISC-V core. Replaces the
//  single-cycle Controller/ALUController pair with one sequencing FSM.
//  Decodes opcode/funct3/funct7 and drives the shared-datapath enables, muxes
//  and the ALU operation code, one micro-step per clock.
//  Stalls on a ready/request memory handshake, so it works with multi-cycle
//  instruction/data memories.
// PARAMETERS
//  CNT_W       32  width of perf counters (valid range 8..64)
//  WAIT_LIMIT  0   max cycles waiting on mem_ready before bus error; 0 = no limit
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  opcode        in   7   instr[6:0] from the instruction register
//  funct3        in   3   instr[14:12]
//  funct7        in   7   instr[31:25]
//  branch_taken  in   1   datapath compare result for the current funct3, valid in BRANCH
//  mem_ready     in   1   memory ack; completes the current mem_req this cycle
//  mem_req       out  1   memory access request, held until mem_ready
//  mem_we        out  1   store request (qualified by mem_req)
//  mem_is_instr  out  1   1 = address from PC (fetch); 0 = address from ALU result
//  ir_we         out  1   load instruction register
//  pc_we         out  1   write PC from pc_src
//  pc_src        out  1   0 = PC+4; 1 = ALU branch/jump target
//  alu_src_a     out  2   0 = rs1, 1 = PC, 2 = old PC
//  alu_src_b     out  2   0 = rs2, 1 = imm, 2 = const 4
//  operation     out  4   ALU op (encoding in pkg)
//  reg_write     out  1   register-file write enable
//  wb_sel        out  2   0 = ALU, 1 = mem data, 2 = PC+4
//  illegal       out  1   sticky: undecodable instruction seen
//  bus_err       out  1   sticky: WAIT_LIMIT exceeded
//  state_o       out  4   current state (debug)
// BEHAVIOUR
//  Reset: state = FETCH; illegal, bus_err and counters cleared; all strobes 0.
//  Strobes (pc_we, ir_we, reg_write, mem_req) are Moore outputs, except
//  pc_we/ir_we in FETCH, which are gated by mem_ready.
//  FETCH: mem_req=1, mem_is_instr=1; hold until mem_ready; on that cycle
//   ir_we=1, pc_we=1 (pc_src=0) -> DECODE.
//  DECODE: ALU computes oldPC+imm. Next state is chosen by opcode:
//   0110011 -> EXEC_R;  0010011 -> EXEC_I;  0000011/0100011 -> ADDR;
//   1100011 -> BRANCH;  1101111 -> JAL;  anything else -> HALT, illegal=1.
//  EXEC_R/EXEC_I -> WB_ALU (reg_write=1, wb_sel=0) -> FETCH.
//  ADDR: ALU computes rs1+imm. Load -> MEM_RD; store -> MEM_WR.
//  MEM_RD: mem_req=1, hold until mem_ready -> WB_MEM (reg_write=1, wb_sel=1) -> FETCH.
//  MEM_WR: mem_req=1, mem_we=1, hold until mem_ready -> FETCH.
//  BRANCH: pc_we=branch_taken, pc_src=1 -> FETCH.
//  JAL: reg_write=1, wb_sel=2, pc_we=1, pc_src=1 -> FETCH.
//  HALT: absorbing; all strobes 0; left only by reset.
//  Min latency (cycles, mem_ready=1 at request): R/I 4, load 5, store 4,
//   branch 3, jal 3.
//  Decode: R uses funct7[5] for SUB/SRA; I ignores funct7 except SRAI.
//   Unsupported funct3/funct7 combinations -> HALT, illegal=1.
//  Wait counter: cleared on every state change. If WAIT_LIMIT!=0 and the
//   count reaches WAIT_LIMIT with mem_ready still low -> HALT, bus_err=1,
//   mem_req drops the next cycle.
//  mem_ready outside a mem_req is ignored. Reset mid-wait aborts the access
//   immediately.
// CONFIGURATION
//  RISCV_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W] and
//   instret_cnt[CNT_W].
//   - cycle_cnt increments every cycle except in HALT.
//   - instret_cnt increments on each transition into FETCH from a
//     non-FETCH state.
//   - Both wrap to 0 at overflow and clear on reset.
//  RISCV_PERF_CNT_EN undefined: no counter ports and no counter logic.
// STRUCTURE
//  riscv_mc_pkg holds: state_t enum, opcode localparams, alu_op_t
//   (AND=0000 OR=0001 ADD=0010 SUB=0110 XOR=0011 SLL=0100 SRL=0101 SLT=0111
//   SRA=1000 SLTU=1001), and the src/wb select localparams.
//  Sub-module riscv_mc_aludec: combinational {state, opcode, funct3, funct7}
//   -> operation, plus an illegal flag.
// TESTING
//  1 add x3,x1,x2 with mem_ready tied 1 -> FETCH,DECODE,EXEC_R,WB_ALU;
//    operation=0010; reg_write only in cycle 4.
//  2 lw with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles;
//    WB_MEM once; wb_sel=1.
//  3 beq with branch_taken=1, then 0 -> pc_we=1, pc_src=1 in BRANCH;
//    second case pc_we=0.
//  4 opcode 7'h7F -> HALT; illegal=1; no strobes for 20 cycles; reset -> FETCH.
//  5 WAIT_LIMIT=8, mem_ready held 0 in FETCH -> bus_err=1 after 8 cycles;
//    mem_req=0 afterwards.
//  6 RISCV_PERF_CNT_EN with 3 R-type instructions -> instret_cnt=3,
//    cycle_cnt=12; reset mid-MEM_RD clears both counters and returns to FETCH.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types for the multi-cycle RISC-V control unit: FSM states, opcodes,
// ALU operation codes and datapath select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_FOUR  = 2'd2;
  localparam logic [1:0] WB_ALU      = 2'd0;
  localparam logic [1:0] WB_MEM      = 2'd1;
  localparam logic [1:0] WB_PC4      = 2'd2;
  localparam logic       PC_SRC_PLUS4 = 1'b0;
  localparam logic       PC_SRC_ALU   = 1'b1;

  // Successor of a memory-handshake state once mem_ready arrives.
  function automatic state_t mem_done_next(input state_t s);
    case (s)
      S_FETCH:  return S_DECODE;
      S_MEM_RD: return S_WB_MEM;
      default:  return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// ALU operation decoder: maps {state, opcode, funct3, funct7} to the ALU op
// and flags instruction encodings the core does not support.
module riscv_mc_aludec
  import riscv_mc_pkg::*;
(
  input  state_t      state,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_op_t     operation,
  output logic        illegal
);

  alu_op_t r_op, i_op, b_op;
  logic    f7_base, f7_alt;

  assign f7_base = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);

  always_comb begin
    r_op = ALU_ADD;
    i_op = ALU_ADD;
    case (funct3)
      3'b000: begin r_op = funct7[5] ? ALU_SUB : ALU_ADD; i_op = ALU_ADD; end
      3'b001: begin r_op = ALU_SLL;  i_op = ALU_SLL;  end
      3'b010: begin r_op = ALU_SLT;  i_op = ALU_SLT;  end
      3'b011: begin r_op = ALU_SLTU; i_op = ALU_SLTU; end
      3'b100: begin r_op = ALU_XOR;  i_op = ALU_XOR;  end
      3'b101: begin
        r_op = funct7[5] ? ALU_SRA : ALU_SRL;
        i_op = funct7[5] ? ALU_SRA : ALU_SRL;
      end
      3'b110: begin r_op = ALU_OR;   i_op = ALU_OR;   end
      default: begin r_op = ALU_AND; i_op = ALU_AND;  end
    endcase

    // beq/bne compare by subtraction, blt/bge signed, bltu/bgeu unsigned
    case (funct3[2:1])
      2'b00:   b_op = ALU_SUB;
      2'b10:   b_op = ALU_SLT;
      default: b_op = ALU_SLTU;
    endcase

    case (state)
      S_EXEC_R: operation = r_op;
      S_EXEC_I: operation = i_op;
      S_BRANCH: operation = b_op;
      default:  operation = ALU_ADD;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:      illegal = !(f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      OP_I: begin
        if (funct3 == 3'b001)      illegal = !f7_base;
        else if (funct3 == 3'b101) illegal = !(f7_base || f7_alt);
      end
      OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE:  illegal = (funct3 > 3'b010);
      OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
      OP_JAL:    illegal = 1'b0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RISC-V sequencing FSM with a ready/request memory handshake.
// Optional perf counters (cycle_cnt, instret_cnt) when RISCV_PERF_CNT_EN is defined.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_instr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       operation,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_err,
`ifdef RISCV_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [3:0]       state_o
);

  state_t      state;
  alu_op_t     alu_op;
  logic        dec_illegal;
  logic [31:0] wait_cnt;
  logic        wait_expire;

  riscv_mc_aludec u_aludec (
    .state     (state),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .operation (alu_op),
    .illegal   (dec_illegal)
  );

  assign wait_expire = (WAIT_LIMIT != 0) && (wait_cnt == 32'(WAIT_LIMIT - 1));
  assign operation   = alu_op;
  assign state_o     = state;

  // wait_cnt defaults to clear; only a stalled handshake state keeps counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            state <= mem_done_next(state);
          end else if (wait_expire) begin
            state   <= S_HALT;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state   <= S_HALT;
            illegal <= 1'b1;
          end else begin
            case (opcode)
              OP_R:              state <= S_EXEC_R;
              OP_I:              state <= S_EXEC_I;
              OP_LOAD, OP_STORE: state <= S_ADDR;
              OP_BRANCH:         state <= S_BRANCH;
              OP_JAL:            state <= S_JAL;
              default: begin
                state   <= S_HALT;
                illegal <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
        S_ADDR:             state <= (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state <= S_FETCH;
        default:            state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        ir_we        = mem_ready;
        pc_we        = mem_ready;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_FOUR;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_EXEC_I, S_ADDR: alu_src_b = SRC_B_IMM;
      S_MEM_RD: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      S_BRANCH: begin
        pc_we  = branch_taken;
        pc_src = PC_SRC_ALU;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        pc_we     = 1'b1;
        pc_src    = PC_SRC_ALU;
      end
      default: ;
    endcase
    // Strobes drop as soon as reset rises so an in-flight access is abandoned.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      reg_write = 1'b0;
    end
  end

`ifdef RISCV_PERF_CNT_EN
  logic retire;

  assign retire = (state inside {S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL}) ||
                  (state == S_MEM_WR && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)          instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: per-cycle expectations are queued by
// the stimulus process and compared by a negedge monitor.
module tb_riscv_mc_control;
  import riscv_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2, branch_taken, mem_ready, ready2;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       m_mem_req, m_mem_we, m_mem_is_instr, m_ir_we, m_pc_we, m_pc_src, m_reg_write, m_illegal, m_bus_err;
  logic [1:0] m_src_a, m_src_b, m_wb_sel;
  logic [3:0] m_operation, m_state;
  logic       w_mem_req, w_mem_we, w_mem_is_instr, w_ir_we, w_pc_we, w_pc_src, w_reg_write, w_illegal, w_bus_err;
  logic [1:0] w_src_a, w_src_b, w_wb_sel;
  logic [3:0] w_operation, w_state;
`ifdef RISCV_PERF_CNT_EN
  logic [31:0] m_cyc, m_ins, w_cyc, w_ins;
`endif

  riscv_mc_control u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(m_mem_req), .mem_we(m_mem_we), .mem_is_instr(m_mem_is_instr),
    .ir_we(m_ir_we), .pc_we(m_pc_we), .pc_src(m_pc_src),
    .alu_src_a(m_src_a), .alu_src_b(m_src_b), .operation(m_operation),
    .reg_write(m_reg_write), .wb_sel(m_wb_sel), .illegal(m_illegal), .bus_err(m_bus_err),
`ifdef RISCV_PERF_CNT_EN
    .cycle_cnt(m_cyc), .instret_cnt(m_ins),
`endif
    .state_o(m_state)
  );

  riscv_mc_control #(.WAIT_LIMIT(8)) u_dut_wl (
    .clk(clk), .reset(reset2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(ready2),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_is_instr(w_mem_is_instr),
    .ir_we(w_ir_we), .pc_we(w_pc_we), .pc_src(w_pc_src),
    .alu_src_a(w_src_a), .alu_src_b(w_src_b), .operation(w_operation),
    .reg_write(w_reg_write), .wb_sel(w_wb_sel), .illegal(w_illegal), .bus_err(w_bus_err),
`ifdef RISCV_PERF_CNT_EN
    .cycle_cnt(w_cyc), .instret_cnt(w_ins),
`endif
    .state_o(w_state)
  );

  // bus = {mem_req, mem_we, mem_is_instr, ir_we, pc_we, reg_write}
  localparam logic [5:0] B_RST = 6'b001000, B_F  = 6'b101110, B_FW = 6'b101000;
  localparam logic [5:0] B_0   = 6'b000000, B_RD = 6'b100000, B_WR = 6'b110000;
  localparam logic [5:0] B_WB  = 6'b000001, B_BR = 6'b000010, B_JAL = 6'b000011;

  typedef struct packed {
    logic        sel;
    logic [3:0]  st;
    logic [5:0]  bus;
    logic        chk_op;  logic [3:0] op;
    logic        chk_wb;  logic [1:0] wb;
    logic        chk_pcs; logic       pcs;
    logic        chk_src; logic [3:0] src;
    logic        chk_cnt; logic [31:0] cyc; logic [31:0] ins;
    logic        ill;
    logic        berr;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0, errors = 0;
  logic  ill_m, berr_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic ex(input string nm, input logic [3:0] st, input logic [5:0] bus,
                    input int op = -1, input int wb = -1, input int pcs = -1, input int src = -1,
                    input int cyc = -1, input int ins = -1, input int sel = 0);
    exp_t e;
    e.sel = (sel != 0);
    e.st = st; e.bus = bus;
    e.chk_op  = (op >= 0);  e.op  = op[3:0];
    e.chk_wb  = (wb >= 0);  e.wb  = wb[1:0];
    e.chk_pcs = (pcs >= 0); e.pcs = pcs[0];
    e.chk_src = (src >= 0); e.src = src[3:0];
    e.chk_cnt = (cyc >= 0); e.cyc = cyc; e.ins = ins;
    e.ill  = (sel != 0) ? 1'b0 : ill_m;
    e.berr = (sel != 0) ? berr_w : 1'b0;
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic fetch_dec(input string nm);
    ex({nm, "_fetch"}, S_FETCH, B_F, ALU_ADD, -1, 0, 4'b0110);
    ex({nm, "_dec"}, S_DECODE, B_0, ALU_ADD, -1, -1, 4'b1001);
  endtask

  task automatic run_alu(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input int op, input logic [3:0] xst, input int xsrc);
    opcode = opc; funct3 = f3; funct7 = f7;
    fetch_dec(nm);
    ex({nm, "_exec"}, xst, B_0, op, -1, -1, xsrc);
    ex({nm, "_wb"}, S_WB_ALU, B_WB, -1, 0);
  endtask

  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [3:0]  a_st, a_op, a_src;
    logic [5:0]  a_bus;
    logic [1:0]  a_wb;
    logic        a_pcs, a_ill, a_berr;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.sel) begin
          a_st = w_state; a_op = w_operation; a_src = {w_src_a, w_src_b};
          a_bus = {w_mem_req, w_mem_we, w_mem_is_instr, w_ir_we, w_pc_we, w_reg_write};
          a_wb = w_wb_sel; a_pcs = w_pc_src; a_ill = w_illegal; a_berr = w_bus_err;
        end else begin
          a_st = m_state; a_op = m_operation; a_src = {m_src_a, m_src_b};
          a_bus = {m_mem_req, m_mem_we, m_mem_is_instr, m_ir_we, m_pc_we, m_reg_write};
          a_wb = m_wb_sel; a_pcs = m_pc_src; a_ill = m_illegal; a_berr = m_bus_err;
        end
        chk({nm, "/state"}, 32'(a_st), 32'(e.st));
        chk({nm, "/strobes"}, 32'(a_bus), 32'(e.bus));
        chk({nm, "/ill_berr"}, {30'd0, a_ill, a_berr}, {30'd0, e.ill, e.berr});
        if (e.chk_op)  chk({nm, "/operation"}, 32'(a_op), 32'(e.op));
        if (e.chk_wb)  chk({nm, "/wb_sel"}, 32'(a_wb), 32'(e.wb));
        if (e.chk_pcs) chk({nm, "/pc_src"}, 32'(a_pcs), 32'(e.pcs));
        if (e.chk_src) chk({nm, "/alu_src"}, 32'(a_src), 32'(e.src));
`ifdef RISCV_PERF_CNT_EN
        if (e.chk_cnt) begin
          chk({nm, "/cycle_cnt"}, e.sel ? w_cyc : m_cyc, e.cyc);
          chk({nm, "/instret_cnt"}, e.sel ? w_ins : m_ins, e.ins);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1; reset2 = 1'b1; ready2 = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    ill_m = 1'b0; berr_w = 1'b0;
    @(posedge clk); #1;
    ex("reset", S_FETCH, B_RST, -1, -1, -1, -1, 0, 0);
    reset = 1'b0; mem_ready = 1'b1;

    run_alu("add", OP_R, 3'b000, 7'h00, ALU_ADD, S_EXEC_R, 4'b0000);
    run_alu("sub", OP_R, 3'b000, 7'h20, ALU_SUB, S_EXEC_R, 4'b0000);
    run_alu("sra", OP_R, 3'b101, 7'h20, ALU_SRA, S_EXEC_R, 4'b0000);

    // lw with a 3-cycle data stall; first fetch also samples the counters
    opcode = OP_LOAD; funct3 = 3'b010; funct7 = 7'h00;
    ex("lw_fetch", S_FETCH, B_F, ALU_ADD, -1, 0, 4'b0110, 12, 3);
    ex("lw_dec", S_DECODE, B_0, ALU_ADD, -1, -1, 4'b1001);
    ex("lw_addr", S_ADDR, B_0, ALU_ADD, -1, -1, 4'b0001);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) ex("lw_wait", S_MEM_RD, B_RD);
    mem_ready = 1'b1;
    ex("lw_ack", S_MEM_RD, B_RD);
    ex("lw_wb", S_WB_MEM, B_WB, -1, 1);

    opcode = OP_STORE; funct3 = 3'b010;
    fetch_dec("sw");
    ex("sw_addr", S_ADDR, B_0, ALU_ADD, -1, -1, 4'b0001);
    ex("sw_mem", S_MEM_WR, B_WR);

    opcode = OP_BRANCH; funct3 = 3'b000; branch_taken = 1'b1;
    fetch_dec("beq_t");
    ex("beq_t_br", S_BRANCH, B_BR, ALU_SUB, -1, 1);
    branch_taken = 1'b0;
    fetch_dec("beq_nt");
    ex("beq_nt_br", S_BRANCH, B_0, ALU_SUB, -1, 1);

    opcode = OP_JAL;
    fetch_dec("jal");
    ex("jal_x", S_JAL, B_JAL, -1, 2, 1);

    run_alu("xori", OP_I, 3'b100, 7'h55, ALU_XOR, S_EXEC_I, 4'b0001);
    run_alu("srai", OP_I, 3'b101, 7'h20, ALU_SRA, S_EXEC_I, 4'b0001);

    // reset in the middle of a stalled load
    opcode = OP_LOAD; funct3 = 3'b010; funct7 = 7'h00;
    fetch_dec("lw2");
    ex("lw2_addr", S_ADDR, B_0, ALU_ADD, -1, -1, 4'b0001);
    mem_ready = 1'b0;
    ex("lw2_wait", S_MEM_RD, B_RD);
    reset = 1'b1;
    ex("rst_mid", S_FETCH, B_RST, -1, -1, -1, -1, 0, 0);
    reset = 1'b0;
    ex("rst_rel", S_FETCH, B_FW, -1, -1, -1, -1, 0, 0);

    // undecodable opcode: HALT absorbs, ignores inputs, counters freeze
    opcode = 7'h7F; mem_ready = 1'b1;
    fetch_dec("ill");
    ill_m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      branch_taken = ~i[0];
      ex("halt", S_HALT, B_0, -1, -1, -1, -1, 3, 0);
    end
    reset = 1'b1; ill_m = 1'b0;
    ex("halt_rst", S_FETCH, B_RST, -1, -1, -1, -1, 0, 0);
    reset = 1'b0; mem_ready = 1'b1;

    // R-type with unsupported funct7
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'h01;
    fetch_dec("mul");
    ill_m = 1'b1;
    ex("mul_halt", S_HALT, B_0);
    ex("mul_halt2", S_HALT, B_0);
    reset = 1'b1; ill_m = 1'b0;
    ex("rst3", S_FETCH, B_RST);
    reset = 1'b0;

    // WAIT_LIMIT=8 instance with memory never answering
    reset2 = 1'b0;
    for (int i = 0; i < 8; i++) ex("wl_wait", S_FETCH, B_FW, -1, -1, -1, -1, -1, -1, 1);
    berr_w = 1'b1;
    for (int i = 0; i < 3; i++) ex("wl_berr", S_HALT, B_0, -1, -1, -1, -1, -1, -1, 1);

    @(negedge clk); #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
